// File: rtl/ps2_key_fifo.sv
// Show-ahead FIFO between the PS/2 keyboard character path and the CPU I/O port.
// It turns the character-ready level into single pushes and reports data, status and an interrupt request.
module ps2_key_fifo #(
    parameter int DEPTH_BITS = 4,
    parameter int IRQ_LEVEL  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            ps2_char,
    input  logic                  ps2_char_rdy,
    input  logic                  key_pop,
    input  logic                  key_clear,
    input  logic                  irq_en,
    output logic [7:0]            key_data,
    output logic                  key_valid,
    output logic                  key_full,
    output logic                  key_overflow,
    output logic [DEPTH_BITS:0]   key_count,
    output logic [7:0]            key_status,
    output logic                  key_irq
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   IRQ_THRESH = (DEPTH_BITS + 1)'(IRQ_LEVEL);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE    = (DEPTH_BITS)'(1);
    localparam logic [DEPTH_BITS:0]   CNT_ONE    = (DEPTH_BITS + 1)'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_reg;
    logic [DEPTH_BITS-1:0] rd_ptr_reg;
    logic [DEPTH_BITS:0]   count_reg;
    logic                  overflow_reg;
    logic                  rdy_d_reg;

    logic push;
    logic empty;
    logic full;
    logic do_write;
    logic do_read;
    logic irq_pending;

    assign push  = ps2_char_rdy & ~rdy_d_reg;
    assign empty = (count_reg == '0);
    assign full  = count_reg[DEPTH_BITS];

    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    assign do_write = push & ~key_clear & (~full | key_pop);
    assign do_read  = key_pop & ~key_clear & ~empty;

    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem[wr_ptr_reg] <= ps2_char;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            rdy_d_reg    <= 1'b1;
        end else begin
            rdy_d_reg <= ps2_char_rdy;
            if (key_clear) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (do_write) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                end
                if (do_read) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
                if (do_write && !do_read) begin
                    count_reg <= count_reg + CNT_ONE;
                end else if (!do_write && do_read) begin
                    count_reg <= count_reg - CNT_ONE;
                end
                if (push && full && !key_pop) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    assign irq_pending  = (count_reg >= IRQ_THRESH);
    assign key_data     = empty ? 8'h00 : mem[rd_ptr_reg];
    assign key_valid    = ~empty;
    assign key_full     = full;
    assign key_overflow = overflow_reg;
    assign key_count    = count_reg;
    assign key_status   = {~empty, full, overflow_reg, irq_pending, 4'b0000};
    assign key_irq      = irq_en & irq_pending;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Bench for ps2_key_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_ps2_key_fifo;

    localparam int DB    = 4;
    localparam int DEPTH = 1 << DB;
    localparam int LVL   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    ps2_char;
    logic          ps2_char_rdy;
    logic          key_pop;
    logic          key_clear;
    logic          irq_en;
    logic [7:0]    key_data;
    logic          key_valid;
    logic          key_full;
    logic          key_overflow;
    logic [DB:0]   key_count;
    logic [7:0]    key_status;
    logic          key_irq;

    ps2_key_fifo #(.DEPTH_BITS(DB), .IRQ_LEVEL(LVL)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_char     (ps2_char),
        .ps2_char_rdy (ps2_char_rdy),
        .key_pop      (key_pop),
        .key_clear    (key_clear),
        .irq_en       (irq_en),
        .key_data     (key_data),
        .key_valid    (key_valid),
        .key_full     (key_full),
        .key_overflow (key_overflow),
        .key_count    (key_count),
        .key_status   (key_status),
        .key_irq      (key_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of characters plus the sticky overflow flag.
    logic [7:0] q[$];
    bit         m_ovf   = 1'b0;
    bit         m_rdy_d = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit rdy, input logic [7:0] ch,
                              input bit pop, input bit clr);
        bit pushed;
        if (rst) begin
            q.delete();
            m_ovf   = 1'b0;
            m_rdy_d = 1'b1;
            return;
        end
        pushed  = rdy && !m_rdy_d;
        m_rdy_d = rdy;
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (pushed && pop && q.size() > 0) begin
            void'(q.pop_front());
            q.push_back(ch);
        end else if (pushed) begin
            if (q.size() < DEPTH) q.push_back(ch);
            else m_ovf = 1'b1;
        end else if (pop && q.size() > 0) begin
            void'(q.pop_front());
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e_data;
        bit e_valid, e_full, e_pend;
        e_valid = (q.size() > 0);
        e_full  = (q.size() == DEPTH);
        e_pend  = (q.size() >= LVL);
        e_data  = e_valid ? q[0] : 8'h00;
        check("key_data",     key_data,     e_data);
        check("key_valid",    key_valid,    e_valid);
        check("key_full",     key_full,     e_full);
        check("key_overflow", key_overflow, m_ovf);
        check("key_count",    key_count,    q.size());
        check("key_status",   key_status,   {e_valid, e_full, m_ovf, e_pend, 4'b0000});
        check("key_irq",      key_irq,      irq_en & e_pend);
    endtask

    // One clock cycle: drive inputs, step the model at the edge, check 1 ns later.
    task automatic cyc(input bit rst, input bit rdy, input logic [7:0] ch,
                       input bit pop, input bit clr);
        reset        = rst;
        ps2_char_rdy = rdy;
        ps2_char     = ch;
        key_pop      = pop;
        key_clear    = clr;
        @(posedge clk);
        model_edge(rst, rdy, ch, pop, clr);
        #1;
        check_outputs();
        $display("cyc rst=%0b rdy=%0b ch=%02h pop=%0b clr=%0b -> data=%02h cnt=%0d st=%02h irq=%0b",
                 rst, rdy, ch, pop, clr, key_data, key_count, key_status, key_irq);
    endtask

    task automatic push_char(input logic [7:0] ch);
        cyc(0, 1, ch, 0, 0);
        cyc(0, 0, ch, 0, 0);
    endtask

    task automatic pop_one();
        cyc(0, 0, 8'h00, 1, 0);
    endtask

    task automatic clear_fifo();
        cyc(0, 0, 8'h00, 0, 1);
    endtask

    initial begin
        reset = 1'b1; ps2_char = 8'h00; ps2_char_rdy = 1'b1;
        key_pop = 1'b0; key_clear = 1'b0; irq_en = 1'b0;
        #1;

        // Reset with ready held high: no entry after release
        cyc(1, 1, 8'h41, 0, 0);
        cyc(1, 1, 8'h41, 0, 0);
        check("reset_status", key_status, 8'h00);
        cyc(0, 1, 8'h41, 0, 0);
        cyc(0, 1, 8'h41, 0, 0);
        check("no_push_after_reset", key_count, 0);
        check("no_data_after_reset", key_data, 8'h00);
        cyc(0, 0, 8'h41, 0, 0);
        cyc(0, 1, 8'h41, 0, 0);
        check("first_push_data", key_data, 8'h41);
        check("first_push_valid", key_valid, 1);
        cyc(0, 0, 8'h41, 0, 0);

        // Long ready level gives one entry
        clear_fifo();
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h61, 0, 0);
        cyc(0, 0, 8'h61, 0, 0);
        check("long_level_count", key_count, 1);

        // Fill, overflow, drain in order
        clear_fifo();
        for (int i = 0; i < 16; i++) push_char(8'h30 + 8'(i));
        push_char(8'h40);
        check("fill_full", key_full, 1);
        check("fill_overflow", key_overflow, 1);
        check("fill_count", key_count, 16);
        for (int i = 0; i < 16; i++) begin
            check("drain_order", key_data, 8'h30 + 8'(i));
            pop_one();
        end
        check("drain_empty", key_valid, 0);

        // Push with pop while full
        clear_fifo();
        for (int i = 0; i < 16; i++) push_char(8'h70 + 8'(i));
        cyc(0, 1, 8'h55, 1, 0);
        check("full_pushpop_count", key_count, 16);
        check("full_pushpop_ovf", key_overflow, 0);
        cyc(0, 0, 8'h55, 0, 0);
        for (int i = 0; i < 15; i++) pop_one();
        check("last_entry", key_data, 8'h55);
        pop_one();
        pop_one();
        check("pop_empty_count", key_count, 0);

        // Push with pop on empty
        cyc(0, 1, 8'h5a, 1, 0);
        check("empty_pushpop_count", key_count, 1);
        cyc(0, 0, 8'h00, 0, 0);
        clear_fifo();

        // Pointer wrap-around
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) push_char(8'(r * 3 + k + 1));
            for (int k = 0; k < 3; k++) begin
                check("wrap_order", key_data, 8'(r * 3 + k + 1));
                pop_one();
            end
        end

        // Interrupt threshold and clear-with-push
        irq_en = 1'b1;
        clear_fifo();
        for (int i = 0; i < 3; i++) push_char(8'h20 + 8'(i));
        check("irq_below", key_irq, 0);
        push_char(8'h23);
        check("irq_at_level", key_irq, 1);
        cyc(0, 1, 8'h24, 0, 1);
        check("clear_count", key_count, 0);
        check("clear_irq", key_irq, 0);
        cyc(0, 0, 8'h24, 0, 0);

        // Random traffic, including occasional reset and clear
        for (int n = 0; n < 1500; n++) begin
            bit rst, rdy, pop, clr;
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 2) != 0) ? ~ps2_char_rdy : ps2_char_rdy;
            pop = (n % 400 < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            if (n % 100 == 0) irq_en = $urandom_range(0, 1);
            cyc(rst, rdy, 8'($urandom), pop, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
